add_serial_p: RTL and testbench
===============================

# add_serial_p

Parametrised bit-serial adder/subtractor, the successor to the fixed 8-bit serial adder in the arithmetic datapath. It processes operands of width WIDTH in chunks of BPC bits per clock, so a throughput/area trade is set by parameter. It adds subtract mode, carry/borrow-in, carry-out and signed overflow, plus explicit busy/done status. It sits between the operand register file and the result bus, wherever area matters more than single-cycle latency.

## Interface

- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- BPC, 1, bits processed per ADD cycle; WIDTH must be divisible by BPC.
- N (local), WIDTH/BPC, number of ADD cycles per operation.

Ports:

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low; clears all state immediately.
- en  input  1  start request; sampled only in IDLE.
- mode  input  1  0 = add, 1 = subtract (a − b); captured at start.
- cin  input  1  carry-in (add) or borrow-in (subtract); captured at start.
- a  input  WIDTH  operand A; captured at start.
- b  input  WIDTH  operand B; captured at start.
- out  output  WIDTH  result shift register; valid when done=1, then held.
- cout  output  1  final carry-out; for subtract, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow of the full result.
- busy  output  1  high while state = ADD.
- done  output  1  one-cycle pulse in state DONE.

## Operation

- States: IDLE (0), ADD (1), DONE (2); the state encoding is 2 bits, and the unused code 3 returns to IDLE.
- IDLE:
  - If en=1: load a_reg←a and b_reg←(mode ? ~b : b).
  - Set carry←(mode ? ~cin : cin), count←0, out←0, then go to ADD.
  - If en=0: stay in IDLE; out, cout and ovf hold their values.
- ADD, each cycle:
  - Compute the chunk sum s = a_reg[BPC-1:0] + b_reg[BPC-1:0] + carry as a (BPC+1)-bit value.
  - out←{s[BPC-1:0], out[WIDTH-1:BPC]}, so chunks enter at the MSB end and the LSB chunk ends at the bottom.
  - a_reg and b_reg shift right by BPC; carry←s[BPC]; count←count+1.
  - On the count = N−1 cycle:
    - cout←s[BPC].
    - ovf←(carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1). The carry into the MSB is computed inside the last chunk.
    - Next state is DONE.
- DONE: done=1 for one cycle, then unconditionally IDLE. An en in DONE is ignored; a new start needs en in IDLE.
- Subtract result is a + ~b + ~cin mod 2^WIDTH, i.e. a − b − cin.
- en, mode, cin, a and b are ignored outside IDLE. Operand changes during ADD do not affect the result.
- count width is clog2(N), minimum 1 bit.

## Timing

- Reset (rst=0, async):
  - state=IDLE; out, cout, ovf, busy, done, a_reg, b_reg, carry and count all 0.
  - Reset mid-operation aborts immediately with no done pulse.
  - The first start is accepted on the first rising edge with rst=1 and en=1.
- Start edge E0 (IDLE, en=1): busy=1 after E0. ADD edges are E1..EN.
- done=1 and out/cout/ovf are valid in the cycle after EN; busy=0 in that cycle.
- The earliest next start is the edge after the DONE cycle. Start-to-start period is N+2 cycles.
- Latency from the start edge to done is N+1 edges.
- With en held high continuously, operations run back-to-back every N+2 cycles, each capturing fresh operands.
- BPC=WIDTH gives N=1: one ADD cycle, and done appears 2 edges after start.

## Test plan

- WIDTH=8, BPC=1, add 0x5A+0x3C, cin=0 -> out=0x96, cout=0, ovf=1. busy high exactly 8 cycles, then done for 1 cycle.
- WIDTH=8, BPC=1, add 0xFF+0x01, cin=0 -> out=0x00, cout=1, ovf=0. Then add 0x00+0x00 with cin=1 -> out=0x01, cout=0.
- WIDTH=8, BPC=2, subtract 0x10−0x20, cin=0 -> out=0xF0, cout=0 (borrow), ovf=0. Subtract 0x80−0x01 -> out=0x7F, cout=1, ovf=1. busy lasts 4 cycles.
- WIDTH=16, BPC=4, add 0x7FFF+0x0001 -> out=0x8000, cout=0, ovf=1, done 5 edges after start. With BPC=16, the same add gives done 2 edges after start.
- Start add 0x12+0x34, then during ADD pulse en and change a to 0xFF and mode to 1. The result must be 0x46 with only one done pulse, and en during the DONE cycle must not start a new operation.
- Assert rst=0 asynchronously at ADD cycle 3 -> all outputs 0 immediately and no done. After release, start 0x01+0x01 -> out=0x02.

Source files
------------

// File: rtl/add_serial_p_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// master drives operands and start; slave returns result and status.
interface add_serial_p_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             mode;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, cin, a, b,
    input  out, cout, ovf, busy, done
  );

  modport slave (
    input  en, mode, cin, a, b,
    output out, cout, ovf, busy, done
  );
endinterface

// File: rtl/add_serial_p.sv
// Bit-serial adder/subtractor: WIDTH-bit operands processed BPC bits per
// clock, with carry/borrow-in, carry-out, signed overflow and busy/done.
module add_serial_p #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic          clk,
  input  logic          rst,
  add_serial_p_if.slave bus
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [BPC:0]     sum;
  logic             c_msb;

  always_comb begin
    sum   = {1'b0, a_q[BPC-1:0]} + {1'b0, b_q[BPC-1:0]} + {{BPC{1'b0}}, carry_q};
    // Carry into the chunk's top bit, recovered from that bit's sum and inputs.
    c_msb = sum[BPC-1] ^ a_q[BPC-1] ^ b_q[BPC-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          a_d     = bus.a;
          b_d     = bus.mode ? ~bus.b : bus.b;
          carry_d = bus.mode ? ~bus.cin : bus.cin;
          cnt_d   = '0;
          out_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        // Shift form keeps BPC == WIDTH legal without a reversed slice.
        out_d   = (out_q >> BPC) | (WIDTH'(sum[BPC-1:0]) << (WIDTH - BPC));
        a_d     = a_q >> BPC;
        b_d     = b_q >> BPC;
        carry_d = sum[BPC];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          cout_d  = sum[BPC];
          ovf_d   = c_msb ^ sum[BPC];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.out  = out_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = (state_q == S_ADD);
  assign bus.done = (state_q == S_DONE);

endmodule

// File: tb/tb_add_serial_p.sv
// Scoreboard bench for add_serial_p: four configurations share operands,
// each with its own start line, expected-result queue and monitor.
module tb_add_serial_p;

  typedef struct {
    logic [15:0] out;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  localparam int WK [4] = '{8, 8, 16, 16};
  localparam int NK [4] = '{8, 4, 4, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en_v;
  logic        mode, cin;
  logic [15:0] a, b;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [15:0] out_w  [4];
  logic        cout_w [4];
  logic        ovf_w  [4];
  logic        busy_w [4];
  logic        done_w [4];

  exp_t q0[$], q1[$], q2[$], q3[$];
  int   busy_cnt [4];
  int   done_cnt [4];
  bit   prev_done [4];

  add_serial_p_if #(.WIDTH(8))  if0 ();
  add_serial_p_if #(.WIDTH(8))  if1 ();
  add_serial_p_if #(.WIDTH(16)) if2 ();
  add_serial_p_if #(.WIDTH(16)) if3 ();

  add_serial_p #(.WIDTH(8),  .BPC(1))  u0 (.clk(clk), .rst(rst), .bus(if0));
  add_serial_p #(.WIDTH(8),  .BPC(2))  u1 (.clk(clk), .rst(rst), .bus(if1));
  add_serial_p #(.WIDTH(16), .BPC(4))  u2 (.clk(clk), .rst(rst), .bus(if2));
  add_serial_p #(.WIDTH(16), .BPC(16)) u3 (.clk(clk), .rst(rst), .bus(if3));

  assign if0.en = en_v[0]; assign if0.mode = mode; assign if0.cin = cin;
  assign if0.a = a[7:0];   assign if0.b = b[7:0];
  assign if1.en = en_v[1]; assign if1.mode = mode; assign if1.cin = cin;
  assign if1.a = a[7:0];   assign if1.b = b[7:0];
  assign if2.en = en_v[2]; assign if2.mode = mode; assign if2.cin = cin;
  assign if2.a = a;        assign if2.b = b;
  assign if3.en = en_v[3]; assign if3.mode = mode; assign if3.cin = cin;
  assign if3.a = a;        assign if3.b = b;

  assign out_w[0] = {8'h00, if0.out}; assign cout_w[0] = if0.cout; assign ovf_w[0] = if0.ovf;
  assign busy_w[0] = if0.busy; assign done_w[0] = if0.done;
  assign out_w[1] = {8'h00, if1.out}; assign cout_w[1] = if1.cout; assign ovf_w[1] = if1.ovf;
  assign busy_w[1] = if1.busy; assign done_w[1] = if1.done;
  assign out_w[2] = if2.out; assign cout_w[2] = if2.cout; assign ovf_w[2] = if2.ovf;
  assign busy_w[2] = if2.busy; assign done_w[2] = if2.done;
  assign out_w[3] = if3.out; assign cout_w[3] = if3.cout; assign ovf_w[3] = if3.ovf;
  assign busy_w[3] = if3.busy; assign done_w[3] = if3.done;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference: a + b' + c' as plain unsigned and signed integer sums.
  function automatic exp_t model(input int w, input bit m, input bit c,
                                 input logic [15:0] av, input logic [15:0] bv);
    exp_t   e;
    longint full, half, mask, am, bm, cm, sum, sa, sb, ssum;
    full = longint'(1) << w;
    half = longint'(1) << (w - 1);
    mask = full - 1;
    am   = longint'(av) & mask;
    bm   = m ? (~longint'(bv)) & mask : longint'(bv) & mask;
    cm   = (m ? !c : c) ? 1 : 0;
    sum  = am + bm + cm;
    sa   = (am >= half) ? am - full : am;
    sb   = (bm >= half) ? bm - full : bm;
    ssum = sa + sb + cm;
    e.out  = 16'(sum & mask);
    e.cout = ((sum >> w) & 1) != 0;
    e.ovf  = (ssum >= half) || (ssum < -half);
    e.cyc  = 0;
    return e;
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      2:       return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic push_e(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      2:       q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic pop_e(input int k, output exp_t e);
    case (k)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      2:       e = q2.pop_front();
      default: e = q3.pop_front();
    endcase
  endtask

  task automatic clear_q();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
  endtask

  task automatic chk(input string nm, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse and checks result/timing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < 4; k++) begin
          busy_cnt[k]  = 0;
          prev_done[k] = 1'b0;
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (busy_w[k]) busy_cnt[k]++;
          if (done_w[k]) begin
            done_cnt[k]++;
            if (prev_done[k]) begin
              checks++; errors++;
              $display("FAIL done_width dut%0d: done high on consecutive cycles", k);
            end
            checks++;
            if (qsize(k) == 0) begin
              errors++;
              $display("FAIL unexpected_done dut%0d: done with no operation pending", k);
            end else begin
              pop_e(k, e);
              if ({cout_w[k], ovf_w[k], out_w[k]} !== {e.cout, e.ovf, e.out}) begin
                errors++;
                $display("FAIL result dut%0d: got cout=%b ovf=%b out=%h expected cout=%b ovf=%b out=%h",
                         k, cout_w[k], ovf_w[k], out_w[k], e.cout, e.ovf, e.out);
              end
              checks++;
              if (cyc - e.cyc != NK[k]) begin
                errors++;
                $display("FAIL latency dut%0d: got %0d expected %0d", k, cyc - e.cyc, NK[k]);
              end
              checks++;
              if (busy_cnt[k] != NK[k] || busy_w[k]) begin
                errors++;
                $display("FAIL busy dut%0d: got %0d cycles (busy now %b) expected %0d",
                         k, busy_cnt[k], busy_w[k], NK[k]);
              end
            end
            busy_cnt[k] = 0;
          end
          prev_done[k] = done_w[k];
        end
      end
    end
  end

  task automatic start(input logic [3:0] mask, input bit m, input bit c,
                       input logic [15:0] av, input logic [15:0] bv, output int c0);
    exp_t e;
    @(negedge clk);
    mode = m; cin = c; a = av; b = bv; en_v = mask;
    @(posedge clk);
    @(negedge clk);
    en_v = '0;
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) begin
        e = model(WK[k], m, c, av, bv);
        e.cyc = cyc;
        push_e(k, e);
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (qsize(0) + qsize(1) + qsize(2) + qsize(3) == 0) break;
    end
    if (qsize(0) + qsize(1) + qsize(2) + qsize(3) != 0) begin
      checks++; errors++;
      $display("FAIL timeout: %0d operations still pending",
               qsize(0) + qsize(1) + qsize(2) + qsize(3));
      clear_q();
    end
  endtask

  task automatic op(input logic [3:0] mask, input bit m, input bit c,
                    input logic [15:0] av, input logic [15:0] bv);
    int c0;
    start(mask, m, c, av, bv, c0);
    wait_idle();
  endtask

  initial begin
    int   c0, d0;
    exp_t e;
    rst = 1'b0; en_v = '0; mode = 1'b0; cin = 1'b0; a = '0; b = '0;
    for (int k = 0; k < 4; k++) done_cnt[k] = 0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++)
      chk($sformatf("reset_state dut%0d", k),
          {out_w[k], cout_w[k], ovf_w[k], busy_w[k], done_w[k]}, '0);
    rst = 1'b1;

    op(4'b1111, 1'b0, 1'b0, 16'h005A, 16'h003C);
    chk("add_5A_3C", {2'b00, cout_w[0], ovf_w[0], out_w[0]}, {2'b00, 1'b0, 1'b1, 16'h0096});
    op(4'b1111, 1'b0, 1'b0, 16'h00FF, 16'h0001);
    chk("add_FF_01", {2'b00, cout_w[0], ovf_w[0], out_w[0]}, {2'b00, 1'b1, 1'b0, 16'h0000});
    op(4'b1111, 1'b0, 1'b1, 16'h0000, 16'h0000);
    chk("add_cin", {2'b00, cout_w[0], ovf_w[0], out_w[0]}, {2'b00, 1'b0, 1'b0, 16'h0001});
    op(4'b1111, 1'b1, 1'b0, 16'h0010, 16'h0020);
    chk("sub_10_20", {2'b00, cout_w[1], ovf_w[1], out_w[1]}, {2'b00, 1'b0, 1'b0, 16'h00F0});
    op(4'b1111, 1'b1, 1'b0, 16'h0080, 16'h0001);
    chk("sub_80_01", {2'b00, cout_w[1], ovf_w[1], out_w[1]}, {2'b00, 1'b1, 1'b1, 16'h007F});
    op(4'b1111, 1'b0, 1'b0, 16'h7FFF, 16'h0001);
    chk("add16_b4", {2'b00, cout_w[2], ovf_w[2], out_w[2]}, {2'b00, 1'b0, 1'b1, 16'h8000});
    chk("add16_b16", {2'b00, cout_w[3], ovf_w[3], out_w[3]}, {2'b00, 1'b0, 1'b1, 16'h8000});

    // Operand/en changes during ADD and en during DONE must be ignored.
    d0 = done_cnt[0];
    start(4'b0001, 1'b0, 1'b0, 16'h0012, 16'h0034, c0);
    repeat (2) @(negedge clk);
    a = 16'h00FF; mode = 1'b1; en_v[0] = 1'b1;
    @(negedge clk);
    en_v[0] = 1'b0;
    for (int i = 0; i < 40 && cyc < c0 + NK[0]; i++) @(negedge clk);
    en_v[0] = 1'b1;
    @(negedge clk);
    en_v[0] = 1'b0;
    repeat (15) @(negedge clk);
    chk("ignore_en_result", {4'h0, out_w[0]}, {4'h0, 16'h0046});
    chk("ignore_en_done_count", 20'(done_cnt[0] - d0), 20'd1);
    chk("ignore_en_idle", {19'd0, busy_w[0]}, 20'd0);
    wait_idle();

    // en held high: back-to-back operations every N+2 cycles.
    @(negedge clk);
    mode = 1'($urandom); cin = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
    en_v = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      e = model(WK[0], mode, cin, a, b);
      e.cyc = cyc;
      push_e(0, e);
      if (i == 2) en_v = '0;
      mode = 1'($urandom); cin = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
      if (i < 2) repeat (NK[0] + 1) @(negedge clk);
    end
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      logic [3:0] msk;
      msk = 4'($urandom_range(1, 15));
      op(msk, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
    end

    // Asynchronous reset in the middle of an operation.
    op(4'b1111, 1'b0, 1'b0, 16'h00FF, 16'h0001);
    start(4'b1111, 1'b0, 1'b0, 16'h00FF, 16'h00FF, c0);
    repeat (3) @(posedge clk);
    d0 = done_cnt[0];
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++)
      chk($sformatf("async_reset dut%0d", k),
          {out_w[k], cout_w[k], ovf_w[k], busy_w[k], done_w[k]}, '0);
    clear_q();
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("reset_no_done", 20'(done_cnt[0] - d0), 20'd0);
    op(4'b1111, 1'b0, 1'b0, 16'h0001, 16'h0001);
    chk("after_reset_add", {4'h0, out_w[0]}, {4'h0, 16'h0002});

    chk("scoreboard_empty", 20'(qsize(0) + qsize(1) + qsize(2) + qsize(3)), 20'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
